// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: one radix-2 step per CALC cycle, W+2 cycles per operation.
// state | meaning:  IDLE | accept start / mthi / mtlo   CALC | W shift-add or restoring steps   FIX | sign fix, write hi/lo, pulse done
module muldiv_unit #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic         mthi,
    input  logic         mtlo,
    output logic         busy,
    output logic         done,
    output logic         div0,
    output logic [W-1:0] hi_out,
    output logic [W-1:0] lo_out
);

    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt;
    logic           is_div, sign_q, sign_r, b_zero;
    logic [W-1:0]   a_raw, opnd_b;
    logic [2*W-1:0] acc;

    logic           sign_a, sign_b;
    logic [W-1:0]   mag_a, mag_b;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    logic [W:0]     div_shift;
    logic           div_ge;
    logic [W-1:0]   div_sub, div_rem;
    logic [2*W-1:0] div_next;

    assign sign_a = a_in[W-1] & ~op[0];
    assign sign_b = b_in[W-1] & ~op[0];
    assign mag_a  = sign_a ? -a_in : a_in;
    assign mag_b  = sign_b ? -b_in : b_in;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    assign mul_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, opnd_b};
    assign mul_next  = acc[0] ? {mul_sum, acc[W-1:1]} : {1'b0, acc[2*W-1:1]};

    assign div_shift = acc[2*W-1:W-1];
    assign div_ge    = div_shift >= {1'b0, opnd_b};
    assign div_sub   = div_shift[W-1:0] - opnd_b;
    assign div_rem   = div_ge ? div_sub : div_shift[W-1:0];
    assign div_next  = {div_rem, acc[W-2:0], div_ge};

    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CALC;
            CALC:    if (cnt == CW'(W - 1)) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt    <= '0;
            hi_out <= '0;
            lo_out <= '0;
            done   <= 1'b0;
            div0   <= 1'b0;
            acc    <= '0;
            opnd_b <= '0;
            a_raw  <= '0;
            is_div <= 1'b0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            b_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            div0 <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div <= op[1];
                        a_raw  <= a_in;
                        b_zero <= (b_in == '0);
                        sign_q <= sign_a ^ sign_b;
                        sign_r <= sign_a;
                        opnd_b <= mag_b;
                        acc    <= {{W{1'b0}}, mag_a};
                        cnt    <= '0;
                    end else begin
                        if (mthi) hi_out <= a_in;
                        if (mtlo) lo_out <= a_in;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    acc <= is_div ? div_next : mul_next;
                end
                FIX: begin
                    done <= 1'b1;
                    if (is_div && b_zero) begin
                        hi_out <= a_raw;
                        lo_out <= '1;
                        div0   <= 1'b1;
                    end else if (is_div) begin
                        lo_out <= sign_q ? -acc[W-1:0] : acc[W-1:0];
                        hi_out <= sign_r ? -acc[2*W-1:W] : acc[2*W-1:W];
                    end else begin
                        {hi_out, lo_out} <= sign_q ? -acc : acc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against a plain-arithmetic HI/LO reference model.
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset, start, mthi, mtlo;
    logic [1:0]   op;
    logic [W-1:0] a_in, b_in;
    logic         busy, done, div0;
    logic [W-1:0] hi_out, lo_out;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    muldiv_unit #(.W(W)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .a_in  (a_in),
        .b_in  (b_in),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi_out(hi_out),
        .lo_out(lo_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] eh, output logic [W-1:0] el, output logic ez);
        longint      sa, sb, q, r;
        logic [63:0] pv;
        sa = $signed(a);
        sb = $signed(b);
        ez = 1'b0;
        case (o)
            2'b00: begin pv = sa * sb; eh = pv[63:32]; el = pv[31:0]; end
            2'b01: begin pv = {32'b0, a} * {32'b0, b}; eh = pv[63:32]; el = pv[31:0]; end
            default: begin
                if (b == 0) begin
                    eh = a; el = '1; ez = 1'b1;
                end else if (o == 2'b10) begin
                    q = sa / sb; r = sa % sb;
                    pv = q; el = pv[31:0];
                    pv = r; eh = pv[31:0];
                end else begin
                    el = a / b; eh = a % b;
                end
            end
        endcase
    endfunction

    // disturb: 0 none, 1 start/mthi/mtlo every busy cycle, 2 MULTU start at E5, 3 mtlo together with start
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int disturb);
        logic [W-1:0] eh, el, old_hi, old_lo;
        logic         ez;
        int           n;
        bit           stable;
        model(o, a, b, eh, el, ez);
        old_hi = hi_out;
        old_lo = lo_out;
        start = 1'b1; op = o; a_in = a; b_in = b; mthi = 1'b0; mtlo = (disturb == 3);
        @(posedge clock); #1;
        start = 1'b0; mtlo = 1'b0;
        check({tag, "_busy_e0"}, busy, 1);
        n = 0;
        stable = 1'b1;
        while (!done && n < 100) begin
            start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            if (disturb == 1) begin
                start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
                op = 2'($urandom); a_in = $urandom; b_in = $urandom;
            end
            if (disturb == 2 && n == 4) begin
                start = 1'b1; op = 2'b01; a_in = $urandom; b_in = $urandom;
            end
            @(posedge clock); #1;
            n++;
            if (!done && (hi_out !== old_hi || lo_out !== old_lo)) stable = 1'b0;
        end
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        check({tag, "_latency"}, n, W + 1);
        check({tag, "_hi"}, hi_out, eh);
        check({tag, "_lo"}, lo_out, el);
        check({tag, "_div0"}, div0, ez);
        check({tag, "_busy_done"}, busy, 0);
        check({tag, "_hold"}, stable, 1);
    endtask

    task automatic after_done(input string tag);
        @(posedge clock); #1;
        check({tag, "_done_low"}, done, 0);
        check({tag, "_div0_low"}, div0, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        bit quiet;
        reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; op = 2'b00; a_in = '0; b_in = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_div0", div0, 0);
        check("rst_hi", hi_out, 0);
        check("rst_lo", lo_out, 0);

        start = 1'b1; mthi = 1'b1; mtlo = 1'b1; a_in = 32'hDEAD_BEEF; b_in = 32'd3;
        @(posedge clock); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0; reset = 1'b0;
        check("rst_prio_busy", busy, 0);
        check("rst_prio_hi", hi_out, 0);
        check("rst_prio_lo", lo_out, 0);

        a_in = 32'hA5A5_5A5A; mthi = 1'b1; mtlo = 1'b1;
        @(posedge clock); #1;
        mthi = 1'b0; mtlo = 1'b0;
        check("mv_both_hi", hi_out, 32'hA5A5_5A5A);
        check("mv_both_lo", lo_out, 32'hA5A5_5A5A);
        a_in = 32'h0F0F_0F0F; mtlo = 1'b1;
        @(posedge clock); #1;
        mtlo = 1'b0;
        check("mtlo_only_hi", hi_out, 32'hA5A5_5A5A);
        check("mtlo_only_lo", lo_out, 32'h0F0F_0F0F);

        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5, 0);
        after_done("mult_neg");
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("div_neg7", 2'b10, 32'hFFFF_FFF9, 32'd2, 0);
        after_done("div_neg7");
        run_op("divu_zero", 2'b11, 32'd10, 32'd0, 0);
        after_done("divu_zero");
        run_op("div_zero", 2'b10, 32'hFFFF_FFF0, 32'd0, 0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 0);
        run_op("divu_big", 2'b11, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        after_done("divu_big");

        run_op("ignore_start", 2'b00, 32'h0001_2345, 32'hFFFF_F000, 2);
        quiet = 1'b1;
        repeat (40) begin
            @(posedge clock); #1;
            if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        check("ignore_start_single_done", quiet, 1);

        run_op("busy_noise", 2'b10, 32'h7654_3210, 32'hFFFF_FF85, 1);
        after_done("busy_noise");

        a_in = 32'h1111_1111; mtlo = 1'b1;
        @(posedge clock); #1;
        mtlo = 1'b0;
        run_op("start_mtlo", 2'b01, 32'd3, 32'd4, 3);
        after_done("start_mtlo");

        for (int i = 0; i < 24; i++) begin
            logic [1:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 2'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = '0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = -32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d", i), ro, ra, rb, 0);
        end
        after_done("rand");

        start = 1'b1; op = 2'b10; a_in = 32'h0000_1000; b_in = 32'd7;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_hi", hi_out, 0);
        check("rst_mid_lo", lo_out, 0);
        quiet = 1'b1;
        repeat (40) begin
            @(posedge clock); #1;
            if (done !== 1'b0 || busy !== 1'b0 || hi_out !== '0 || lo_out !== '0) quiet = 1'b0;
        end
        check("rst_mid_no_done", quiet, 1);
        a_in = 32'h1234_5678; mthi = 1'b1;
        @(posedge clock); #1;
        mthi = 1'b0;
        check("rst_mthi_hi", hi_out, 32'h1234_5678);
        check("rst_mthi_lo", lo_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
